// File: rtl/ctr_sched_pkg.sv
// Shared definitions for the counter-request priority scheduler: default
// geometry, channel index names and the scheduler state encoding.
package ctr_sched_pkg;

  // Default geometry: eight counter channels, three-bit channel index.
  localparam int NCH_DEF = 8;
  localparam int CHW_DEF = 3;

  // Channel index assignments.
  localparam int CH_CDUX  = 0;
  localparam int CH_CDUY  = 1;
  localparam int CH_CDUZ  = 2;
  localparam int CH_PIPX  = 3;
  localparam int CH_PIPY  = 4;
  localparam int CH_PIPZ  = 5;
  localparam int CH_SHAFT = 6;
  localparam int CH_TRN   = 7;

  // Scheduler states: wait for a slot, pick a channel, hold the grant.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/ctr_req_latch.sv
// Per-channel request latch: one plus latch, one minus latch and a sticky
// miss flag.  A plus/minus collision cancels both latches; a request that
// coincides with the ack clear of the same latch keeps the latch set.
module ctr_req_latch (
  input  logic clk,
  input  logic rst_,
  input  logic req_p,
  input  logic req_m,
  input  logic ack_clr_p,
  input  logic ack_clr_m,
  input  logic clr_miss,
  output logic lat_p,
  output logic lat_m,
  output logic miss,
  output logic cancel
);

  logic p_reg, m_reg, miss_reg;
  logic p_keep, m_keep;
  logic p_raw, m_raw;
  logic p_next, m_next, miss_next;
  logic miss_evt;

  // Next-state of the latches: set dominates the ack clear, and a channel
  // whose plus and minus would both be set collapses to empty.
  always_comb begin
    p_keep    = p_reg & ~ack_clr_p;
    m_keep    = m_reg & ~ack_clr_m;
    p_raw     = req_p | p_keep;
    m_raw     = req_m | m_keep;
    cancel    = p_raw & m_raw;
    p_next    = p_raw & ~cancel;
    m_next    = m_raw & ~cancel;
    miss_evt  = (req_p & p_keep) | (req_m & m_keep);
    miss_next = miss_evt | (miss_reg & ~clr_miss);
  end

  // Latch state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      p_reg    <= 1'b0;
      m_reg    <= 1'b0;
      miss_reg <= 1'b0;
    end else begin
      p_reg    <= p_next;
      m_reg    <= m_next;
      miss_reg <= miss_next;
    end
  end

  assign lat_p = p_reg;
  assign lat_m = m_reg;
  assign miss  = miss_reg;

endmodule

// File: rtl/ctr_priority_sched.sv
// Counter-request priority scheduler.  Latches plus/minus count pulses per
// channel and hands out one grant at a time into counter memory slots:
// IDLE waits for slot_go, SEL picks a channel, GRANT holds it until ack.
// Optional feature: define CTR_SCHED_RR_EN for round-robin selection
// starting after the last granted channel; default is lowest index first.
module ctr_priority_sched
  import ctr_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CHW = CHW_DEF
) (
  input  logic           clk,
  input  logic           rst_,
  input  logic [NCH-1:0] req_p,
  input  logic [NCH-1:0] req_m,
  input  logic           slot_go,
  input  logic           inh,
  input  logic           ack,
  input  logic           clr_miss,
  output logic           grant_vld,
  output logic [CHW-1:0] grant_ch,
  output logic           grant_dir,
  output logic [NCH-1:0] pend,
  output logic [NCH-1:0] miss,
  output logic           bothz
);

  sched_state_t   state_reg, state_next;
  logic [NCH-1:0] lat_p, lat_m, cancel;
  logic [NCH-1:0] ack_clr_p, ack_clr_m;
  logic           ack_fire;
  logic           sel_found;
  logic [CHW-1:0] sel_ch;
  logic           sel_dir;
  logic [CHW-1:0] grant_ch_reg;
  logic           grant_dir_reg;
  logic           cxl_reg, cxl_next;
  logic           bothz_reg;

  // A grant whose latch was cancelled meanwhile must not clear anything on
  // ack: a fresh request may have re-set that latch after the cancellation.
  assign ack_fire = (state_reg == ST_GRANT) & ack & ~cxl_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ack_clr_p[gi] = ack_fire & (grant_ch_reg == CHW'(gi)) & ~grant_dir_reg;
      assign ack_clr_m[gi] = ack_fire & (grant_ch_reg == CHW'(gi)) &  grant_dir_reg;

      ctr_req_latch u_latch (
        .clk       (clk),
        .rst_      (rst_),
        .req_p     (req_p[gi]),
        .req_m     (req_m[gi]),
        .ack_clr_p (ack_clr_p[gi]),
        .ack_clr_m (ack_clr_m[gi]),
        .clr_miss  (clr_miss),
        .lat_p     (lat_p[gi]),
        .lat_m     (lat_m[gi]),
        .miss      (miss[gi]),
        .cancel    (cancel[gi])
      );
    end
  endgenerate

  assign pend = lat_p | lat_m;

`ifdef CTR_SCHED_RR_EN
  logic [CHW-1:0] rr_ptr_reg;

  // Round-robin pick: first pending channel at or after the pointer.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NCH;
      if (!sel_found && pend[idx]) begin
        sel_found = 1'b1;
        sel_ch    = CHW'(idx);
      end
    end
  end

  // Pointer advances to the channel after each registered grant.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr_reg <= '0;
    end else if (state_reg == ST_SEL && sel_found) begin
      rr_ptr_reg <= (sel_ch == CHW'(NCH - 1)) ? '0 : sel_ch + CHW'(1);
    end
  end
`else
  // Fixed priority pick: lowest-index pending channel wins.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend[k]) begin
        sel_found = 1'b1;
        sel_ch    = CHW'(k);
      end
    end
  end
`endif

  // Minus direction only when the minus latch alone is set.
  assign sel_dir = lat_m[sel_ch] & ~lat_p[sel_ch];

  // Next-state logic; also tracks whether the granted latch got cancelled.
  always_comb begin
    state_next = state_reg;
    cxl_next   = cxl_reg;
    case (state_reg)
      ST_IDLE: begin
        cxl_next = 1'b0;
        if (slot_go && !inh && (|pend)) begin
          state_next = ST_SEL;
        end
      end
      ST_SEL: begin
        // A cancellation during SEL can empty every latch; then give the
        // slot back rather than grant a channel with nothing pending.
        if (sel_found) begin
          state_next = ST_GRANT;
          cxl_next   = cancel[sel_ch];
        end else begin
          state_next = ST_IDLE;
          cxl_next   = 1'b0;
        end
      end
      ST_GRANT: begin
        if (ack) begin
          state_next = ST_IDLE;
          cxl_next   = 1'b0;
        end else begin
          cxl_next = cxl_reg | cancel[grant_ch_reg];
        end
      end
      default: begin
        state_next = ST_IDLE;
        cxl_next   = 1'b0;
      end
    endcase
  end

  // State, grant and cancellation-pulse registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg     <= ST_IDLE;
      cxl_reg       <= 1'b0;
      grant_ch_reg  <= '0;
      grant_dir_reg <= 1'b0;
      bothz_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cxl_reg   <= cxl_next;
      bothz_reg <= |cancel;
      if (state_reg == ST_SEL && sel_found) begin
        grant_ch_reg  <= sel_ch;
        grant_dir_reg <= sel_dir;
      end
    end
  end

  assign grant_vld = (state_reg == ST_GRANT);
  assign grant_ch  = grant_ch_reg;
  assign grant_dir = grant_dir_reg;
  assign bothz     = bothz_reg;

endmodule

// File: doc/ctr_priority_sched.md
CTR_PRIORITY_SCHED -- requirements
Module: ctr_priority_sched

Interface
REQ-001 SHALL have parameter NCH, default 8: number of counter channels (0 CDUX, 1 CDUY, 2 CDUZ, 3 PIPX, 4 PIPY, 5 PIPZ, 6 SHAFT, 7 TRN).
REQ-002 SHALL have parameter CHW, default 3: channel-index width, equal to clog2(NCH).
REQ-003 SHALL have port clk  in  1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port req_p  in  NCH: plus-count request, one-cycle pulse per channel.
REQ-006 SHALL have port req_m  in  NCH: minus-count request, one-cycle pulse per channel.
REQ-007 SHALL have port slot_go  in  1: a counter memory-cycle slot is available this cycle.
REQ-008 SHALL have port inh  in  1: inhibit; new grants are blocked while high.
REQ-009 SHALL have port ack  in  1: the counter cycle for the current grant has completed.
REQ-010 SHALL have port clr_miss  in  1: clears all sticky miss flags.
REQ-011 SHALL have port grant_vld  out  1: a grant is active.
REQ-012 SHALL have port grant_ch  out  CHW: index of the granted channel.
REQ-013 SHALL have port grant_dir  out  1: direction of the grant, 0 = plus, 1 = minus.
REQ-014 SHALL have port pend  out  NCH: per-channel pending indicator (plus OR minus latch).
REQ-015 SHALL have port miss  out  NCH: sticky flag per channel, set when a request pulse is lost.
REQ-016 SHALL have port bothz  out  1: one-cycle pulse when a plus/minus cancellation occurs.

Function
REQ-017 SHALL keep one plus latch and one minus latch per channel; a request pulse sets the matching latch on the next edge.
REQ-018 SHALL set miss[i] when a pulse arrives while the same-direction latch of channel i is already set; the pulse is otherwise dropped.
REQ-019 SHALL clear both latches of a channel on the edge where both are set or would become set, with no grant for that channel, and SHALL pulse bothz for that cycle.
REQ-020 SHALL implement FSM states IDLE, SEL, GRANT.
- IDLE -> SEL: slot_go=1, inh=0, and any pend bit set.
- SEL -> GRANT: after exactly one cycle.
- GRANT -> IDLE: on ack=1.
REQ-021 SHALL, in SEL, register the lowest-index pending channel into grant_ch, with grant_dir=1 only when only the minus latch is set.
REQ-022 SHALL assert grant_vld from GRANT entry until the ack edge, giving 2-cycle latency from slot_go to grant_vld.
REQ-023 SHALL clear the granted latch on the ack edge; a same-direction request arriving in that cycle SHALL win (set dominates) and SHALL not set miss.
REQ-024 SHALL, if the granted channel is cancelled by REQ-019 during GRANT, keep the grant and SHALL not re-set the latch on ack.
REQ-025 SHALL ignore inh once in SEL or GRANT; an in-flight grant completes.
REQ-026 SHALL ignore slot_go outside IDLE and SHALL ignore ack outside GRANT.
REQ-027 SHALL clear miss on clr_miss; a miss event in the same cycle SHALL win.

Reset
REQ-028 SHALL, while rst_=0, clear all latches, put the FSM in IDLE, and drive grant_vld, grant_ch, grant_dir, pend, miss and bothz to 0, including when reset asserts mid-grant.

Configuration
REQ-029 SHALL, with CTR_SCHED_RR_EN defined, select round-robin starting at (last granted channel + 1) mod NCH, with the pointer reset to 0.
REQ-030 SHALL, without CTR_SCHED_RR_EN defined, use the fixed lowest-index priority of REQ-021.

Structure
REQ-031 SHALL place the FSM state enum, the channel index constants and NCH/CHW defaults in package ctr_sched_pkg.
REQ-032 SHALL put the per-channel plus/minus/miss latch logic in sub-module ctr_req_latch, instantiated NCH times.

Verification
REQ-033 SHALL check fixed-priority selection: req_p[5] and req_m[2] pulse, then slot_go -> grant_ch=2, grant_dir=1 two cycles later; ack -> next slot_go grants ch5, dir 0.
REQ-034 SHALL check cancellation: req_p[3] and req_m[3] pulse in the same cycle -> bothz pulses once, pend[3]=0, and slot_go produces no grant.
REQ-035 SHALL check miss handling: two req_p[0] pulses with no grant in between -> miss[0]=1; clr_miss -> miss[0]=0.
REQ-036 SHALL check set-dominant ack: req_p[1] pulse coincident with ack of a ch1 plus grant -> pend[1] stays 1 and miss[1]=0.
REQ-037 SHALL check reset mid-grant: rst_ low during GRANT -> grant_vld=0 immediately; after release, pend=0 and the FSM is in IDLE.
REQ-038 SHALL check round-robin (with CTR_SCHED_RR_EN): all 8 channels pending -> grant order 0,1,...,7 across 8 slot_go/ack pairs.
